trap_sequencer: RTL

- Multi-cycle controller that sequences ECALL/MRET handling around the 5-stage pipeline.
- Accepts a trap or return request from decode, then stalls and flushes fetch/decode while older instructions drain.
- For ECALL, writes mepc and mcause through a dedicated CSR write port, then redirects the PC to mtvec.
- For MRET, redirects the PC to mepc.

---
 rtl/trap_sequencer_pkg.sv | 33 +++
 rtl/trap_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the ECALL/MRET trap sequencer.
// Holds the FSM state encoding, the request kind, the machine-mode CSR
// addresses written during trap entry and the mcause values used.
package trap_pkg;

    // Sequencer states; IDLE must stay at zero so reset decodes to all-quiet outputs.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_DRAIN      = 3'd1,
        S_SAVE_EPC   = 3'd2,
        S_SAVE_CAUSE = 3'd3,
        S_REDIRECT   = 3'd4
    } state_t;

    // Interrupts travel the ECALL path, so two kinds are enough.
    typedef enum logic {
        KIND_ECALL = 1'b0,
        KIND_MRET  = 1'b1
    } kind_t;

    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;
    localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

    // Where the sequence continues once the pipeline has drained:
    // trap entry saves state first, a return goes straight to the redirect.
    function automatic state_t post_drain_state(input kind_t kind);
        return (kind == KIND_ECALL) ? S_SAVE_EPC : S_REDIRECT;
    endfunction

endpackage

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle controller for ECALL / MRET around a 5-stage pipe.
// Accepts a request from decode, stalls and flushes the front end while older
// instructions retire, saves mepc/mcause for trap entry, then redirects the PC.
// Optional build macro: TRAP_IRQ_EN adds irq_in/irq_mie inputs and an id_kill
// output so an external interrupt can be taken on the decode-stage instruction.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic            ecall_flag,
    input  logic            mret_flag,
    input  logic            stall_in,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
`ifdef TRAP_IRQ_EN
    input  logic            irq_in,
    input  logic            irq_mie,
    output logic            id_kill,
`endif
    output logic            trap_stall,
    output logic            trap_flush,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target,
    output logic            busy
);

    // The counter must hold DRAIN_CYCLES-1; keep at least one bit so D=0 still elaborates.
    localparam int CNT_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    kind_t             kind_q, kind_d;

    logic              accept_irq;
    logic              accept_sw;
    logic              in_idle;

    // Low PC bits are forced to zero in the redirect target; they are read nowhere else.
    logic              unused_pc_lsbs;
    assign unused_pc_lsbs = ^{mtvec[1:0], mepc[1:0]};

    assign in_idle = (state_q == S_IDLE);

    // A software request waits for the load-use stall to clear before it is taken.
    assign accept_sw = in_idle && id_valid && !stall_in && (ecall_flag || mret_flag);

`ifdef TRAP_IRQ_EN
    // Interrupts win over ECALL/MRET and ignore stall_in: the ID instruction is killed anyway.
    assign accept_irq = in_idle && id_valid && irq_in && irq_mie;
    // Combinational so the killed instruction never reaches EX; quiet while reset is held.
    assign id_kill    = accept_irq && !rst;
`else
    assign accept_irq = 1'b0;
`endif

    // Next-state, drain counter and captured request context.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        kind_d  = kind_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_irq) begin
                    epc_d   = id_pc;
                    cause_d = XLEN'(CAUSE_MEXT_IRQ);
                    kind_d  = KIND_ECALL;
                    cnt_d   = CNT_INIT;
                    state_d = (DRAIN_CYCLES == 0) ? post_drain_state(KIND_ECALL) : S_DRAIN;
                end else if (accept_sw) begin
                    epc_d   = id_pc;
                    cause_d = XLEN'(CAUSE_ECALL_M);
                    // ECALL has priority when decode flags both.
                    kind_d  = ecall_flag ? KIND_ECALL : KIND_MRET;
                    cnt_d   = CNT_INIT;
                    state_d = (DRAIN_CYCLES == 0)
                              ? post_drain_state(ecall_flag ? KIND_ECALL : KIND_MRET)
                              : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = post_drain_state(kind_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SAVE_EPC:   state_d = S_SAVE_CAUSE;
            S_SAVE_CAUSE: state_d = S_REDIRECT;
            S_REDIRECT:   state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // State and context registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            kind_q  <= KIND_ECALL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            kind_q  <= kind_d;
        end
    end

    // Moore output decode; address/data/target buses stay zero unless their strobe is high.
    always_comb begin
        trap_stall  = 1'b0;
        trap_flush  = 1'b0;
        busy        = 1'b0;
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        unique case (state_q)
            S_IDLE: begin
            end
            S_DRAIN: begin
                trap_stall = 1'b1;
                trap_flush = 1'b1;
                busy       = 1'b1;
            end
            S_SAVE_EPC: begin
                trap_stall = 1'b1;
                trap_flush = 1'b1;
                busy       = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MEPC;
                csr_wdata  = epc_q;
            end
            S_SAVE_CAUSE: begin
                trap_stall = 1'b1;
                trap_flush = 1'b1;
                busy       = 1'b1;
                csr_we     = 1'b1;
                csr_waddr  = CSR_MCAUSE;
                csr_wdata  = cause_q;
            end
            S_REDIRECT: begin
                trap_stall  = 1'b1;
                trap_flush  = 1'b1;
                busy        = 1'b1;
                pc_redirect = 1'b1;
                // Sampled live so an mepc written during SAVE_EPC is seen by a later MRET.
                pc_target   = (kind_q == KIND_ECALL) ? {mtvec[XLEN-1:2], 2'b00}
                                                     : {mepc[XLEN-1:2], 2'b00};
            end
            default: begin
            end
        endcase
    end

endmodule
